mips_fpga_top: RTL and testbench

- Board-level top for the course FPGA: switch/key-driven 32-bit arithmetic unit with LED, 7-segment and UART output.
- Reads two 32-bit operands from eight active-low DIP banks and an opcode from eight active-low user keys.
- Computes a registered result and shows it on 32 LEDs and two 4-digit multiplexed hex displays. The opcode appears on a third single-digit display.

---
 rtl/mips_fpga_top.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mips_fpga_top.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fpga_top.sv
// mips_fpga_top: board-level 32-bit arithmetic unit for the course FPGA.
//
// Two operands come from eight active-low DIP banks (A = banks 3..0, B = banks 7..4) and the
// opcode from eight active-low keys (lowest pressed key wins). The registered result is shown
// on 32 active-low LEDs and on two multiplexed 4-digit hex displays; the opcode is shown on a
// third single-digit display.
//
// Ports:
//   clk_in, sys_rstn             clock, asynchronous active-low reset
//   dip_switch0..7 [7:0]         active-low operand switches
//   user_key [7:0]               active-low opcode keys
//   led_light [31:0]             active-low LEDs, ~result
//   digital_tube0/1 [7:0]        segments {dp,g,f,e,d,c,b,a} for result[15:0] / result[31:16]
//   digital_tube_sel0/1 [3:0]    one-hot digit select, shared scan timing
//   digital_tube2 [7:0]          opcode digit, blank until the first key press
//   digital_tube_sel2            select for tube2, 1 once out of reset
//   uart_rxd                     unused
//   uart_txd                     serial out, idle high
//
// Optional feature macro FPGA_UART_TX_EN: when defined, every change of the result register
// is sent as 4 bytes (LSB byte first, 8N1). Otherwise uart_txd is tied high.
module mips_fpga_top #(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned SCAN_DIV = 25000
) (
    input  logic        clk_in,
    input  logic        sys_rstn,
    input  logic [7:0]  dip_switch0,
    input  logic [7:0]  dip_switch1,
    input  logic [7:0]  dip_switch2,
    input  logic [7:0]  dip_switch3,
    input  logic [7:0]  dip_switch4,
    input  logic [7:0]  dip_switch5,
    input  logic [7:0]  dip_switch6,
    input  logic [7:0]  dip_switch7,
    input  logic [7:0]  user_key,
    output logic [31:0] led_light,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1,
    output logic [7:0]  digital_tube2,
    output logic        digital_tube_sel2,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int unsigned BIT_DIV   = CLK_FREQ / BAUD;
    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        logic [7:0] seg;
        unique case (nib)
            4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [63:0] r_dip_s1, r_dip_s2;
    logic [7:0]  r_key_s1, r_key_s2;
    logic [31:0] r_result, r_led, r_scan_cnt;
    logic        r_op_valid, r_sel2;
    logic [2:0]  r_op;
    logic [1:0]  r_idx;

    logic [31:0] w_a, w_b, w_alu;
    logic [2:0]  w_op;
    logic        w_any_key;
    logic [15:0] w_lo, w_hi;
    logic        w_unused_rxd;

    assign w_unused_rxd = uart_rxd;

    // Sync flops reset to the released level so no key reads as pressed right after reset.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_dip_s1 <= '1;
            r_dip_s2 <= '1;
            r_key_s1 <= '1;
            r_key_s2 <= '1;
        end else begin
            r_dip_s1 <= {dip_switch7, dip_switch6, dip_switch5, dip_switch4,
                         dip_switch3, dip_switch2, dip_switch1, dip_switch0};
            r_dip_s2 <= r_dip_s1;
            r_key_s1 <= user_key;
            r_key_s2 <= r_key_s1;
        end
    end

    assign w_a       = ~r_dip_s2[31:0];
    assign w_b       = ~r_dip_s2[63:32];
    assign w_any_key = ~&r_key_s2;

    // Lowest-numbered pressed key wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_op = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!r_key_s2[i]) w_op = 3'(i);
        end
    end

    always_comb begin
        w_alu = '0;
        unique case (w_op)
            3'd0: w_alu = w_a + w_b;
            3'd1: w_alu = w_a - w_b;
            3'd2: w_alu = w_a * w_b;
            3'd3: w_alu = (w_b == 32'd0) ? 32'd0 : w_a / w_b;
            3'd4: w_alu = w_a & w_b;
            3'd5: w_alu = w_a | w_b;
            3'd6: w_alu = w_a ^ w_b;
            3'd7: w_alu = w_a << w_b[4:0];
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_result   <= '0;
            r_op_valid <= 1'b0;
            r_op       <= '0;
            r_led      <= '1;
            r_sel2     <= 1'b0;
        end else begin
            if (w_any_key) begin
                r_result   <= w_alu;
                r_op_valid <= 1'b1;
                r_op       <= w_op;
            end
            r_led  <= ~r_result;
            r_sel2 <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 32'd1;
        end
    end

    assign w_lo = r_result[15:0];
    assign w_hi = r_result[31:16];

    assign led_light         = r_led;
    assign digital_tube_sel0 = 4'b0001 << r_idx;
    assign digital_tube_sel1 = 4'b0001 << r_idx;
    assign digital_tube0     = hex_seg(w_lo[{r_idx, 2'b00} +: 4]);
    assign digital_tube1     = hex_seg(w_hi[{r_idx, 2'b00} +: 4]);
    assign digital_tube2     = r_op_valid ? hex_seg({1'b0, r_op}) : 8'hFF;
    assign digital_tube_sel2 = r_sel2;

`ifdef FPGA_UART_TX_EN
    localparam logic [31:0] BIT_LAST = 32'(BIT_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    tx_state_e   r_state, w_state_d;
    logic [31:0] r_baud, w_baud_d, r_shift, w_shift_d;
    logic [2:0]  r_bit, w_bit_d;
    logic [1:0]  r_byte, w_byte_d;
    logic        r_pend, w_pend_d, w_tick, w_change, w_txd;

    // Change is seen one cycle early, so the frame starts on the edge that loads the result.
    assign w_change = w_any_key && (w_alu != r_result);

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_baud  <= w_baud_d;
            r_shift <= w_shift_d;
            r_bit   <= w_bit_d;
            r_byte  <= w_byte_d;
            r_pend  <= w_pend_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_baud_d  = r_baud;
        w_shift_d = r_shift;
        w_bit_d   = r_bit;
        w_byte_d  = r_byte;
        w_pend_d  = r_pend;
        w_txd     = 1'b1;
        w_tick    = (r_baud == BIT_LAST);
        if (r_state != StIdle) begin
            w_baud_d = w_tick ? 32'd0 : r_baud + 32'd1;
            if (w_change) w_pend_d = 1'b1;
        end
        unique case (r_state)
            StIdle: begin
                if (w_change) begin
                    w_shift_d = w_alu;
                    w_byte_d  = '0;
                    w_baud_d  = '0;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_txd = 1'b0;
                if (w_tick) begin
                    w_bit_d   = '0;
                    w_state_d = StData;
                end
            end
            StData: begin
                // Shifting right one bit per data bit leaves the next byte at the bottom.
                w_txd = r_shift[0];
                if (w_tick) begin
                    w_shift_d = r_shift >> 1;
                    if (r_bit == 3'd7) w_state_d = StStop;
                    else               w_bit_d   = r_bit + 3'd1;
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (r_byte != 2'd3) begin
                        w_byte_d  = r_byte + 2'd1;
                        w_state_d = StStart;
                    end else if (r_pend || w_change) begin
                        // Only the newest result is sent; intermediate values are dropped.
                        w_shift_d = w_change ? w_alu : r_result;
                        w_pend_d  = 1'b0;
                        w_byte_d  = '0;
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign uart_txd = w_txd;
`else
    logic [31:0] w_unused_bit_div;
    assign w_unused_bit_div = BIT_DIV;
    assign uart_txd         = 1'b1;
`endif

endmodule

// File: tb/tb_mips_fpga_top.sv
// Self-checking bench for mips_fpga_top: randomized operands/keys checked against a
// behavioural model of the result, LED latency, display scan and opcode digit.
module tb_mips_fpga_top;

    logic        clk_in = 1'b0;
    logic        sys_rstn;
    logic [7:0]  dip [8];
    logic [7:0]  user_key;
    logic        uart_rxd;
    logic [31:0] led_light;
    logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
    logic [3:0]  digital_tube_sel0, digital_tube_sel1;
    logic        digital_tube_sel2, uart_txd;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges;

    logic [31:0] exp_result;
    logic        exp_valid;
    logic [2:0]  exp_op;

    mips_fpga_top #(
        .CLK_FREQ(80),
        .BAUD    (10),
        .SCAN_DIV(4)
    ) dut (
        .clk_in           (clk_in),
        .sys_rstn         (sys_rstn),
        .dip_switch0      (dip[0]),
        .dip_switch1      (dip[1]),
        .dip_switch2      (dip[2]),
        .dip_switch3      (dip[3]),
        .dip_switch4      (dip[4]),
        .dip_switch5      (dip[5]),
        .dip_switch6      (dip[6]),
        .dip_switch7      (dip[7]),
        .user_key         (user_key),
        .led_light        (led_light),
        .digital_tube0    (digital_tube0),
        .digital_tube_sel0(digital_tube_sel0),
        .digital_tube1    (digital_tube1),
        .digital_tube_sel1(digital_tube_sel1),
        .digital_tube2    (digital_tube2),
        .digital_tube_sel2(digital_tube_sel2),
        .uart_rxd         (uart_rxd),
        .uart_txd         (uart_txd)
    );

    always #5 clk_in = ~clk_in;

    // Edges since reset release: the scan position is pure arithmetic on this.
    always @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) n_edges <= 0;
        else           n_edges <= n_edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] nib);
        logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[nib];
    endfunction

    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint unsigned p;
        case (op)
            0: return a + b;
            1: return a - b;
            2: begin p = longint'(a) * longint'(b); return p[31:0]; end
            3: return (b == 0) ? 32'd0 : a / b;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            default: return a << (b % 32);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drives inputs on a falling edge and advances the model to what the DUT will settle on.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] keys);
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            dip[i]     = ~a[8*i +: 8];
            dip[i + 4] = ~b[8*i +: 8];
        end
        user_key = keys;
        if (keys != 8'hFF) begin
            for (int i = 7; i >= 0; i--) if (!keys[i]) exp_op = 3'(i);
            exp_result = model_alu(int'(exp_op), a, b);
            exp_valid  = 1'b1;
        end
    endtask

    task automatic check_scan();
        int idx;
        idx = (n_edges / 4) % 4;
        check("sel0", {28'd0, digital_tube_sel0}, 32'(1 << idx));
        check("sel1", {28'd0, digital_tube_sel1}, 32'(1 << idx));
        check("tube0", {24'd0, digital_tube0}, {24'd0, seg_of(exp_result[4*idx +: 4])});
        check("tube1", {24'd0, digital_tube1}, {24'd0, seg_of(exp_result[16 + 4*idx +: 4])});
        check("sel2", {31'd0, digital_tube_sel2}, {31'd0, n_edges >= 1});
    endtask

    task automatic check_reset_state();
        check("rst_led", led_light, 32'hFFFF_FFFF);
        check("rst_sel0", {28'd0, digital_tube_sel0}, 32'h1);
        check("rst_sel1", {28'd0, digital_tube_sel1}, 32'h1);
        check("rst_tube2", {24'd0, digital_tube2}, 32'hFF);
        check("rst_sel2", {31'd0, digital_tube_sel2}, 32'h0);
        check("rst_txd", {31'd0, uart_txd}, 32'h1);
    endtask

    // LED must still show the old value after 3 edges and the new one after 4.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [7:0] keys);
        logic [31:0] prev;
        prev = exp_result;
        drive(a, b, keys);
        repeat (3) tick();
        check("led_lat3", led_light, ~prev);
        tick();
        check("led", led_light, ~exp_result);
        check("tube2", {24'd0, digital_tube2},
              exp_valid ? {24'd0, seg_of({1'b0, exp_op})} : 32'hFF);
        check_scan();
`ifndef FPGA_UART_TX_EN
        check("txd_idle", {31'd0, uart_txd}, 32'h1);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        sys_rstn   = 1'b0;
        user_key   = 8'hFF;
        exp_result = '0;
        exp_valid  = 1'b0;
        exp_op     = '0;
        #100;
        check_reset_state();
        @(negedge clk_in);
        sys_rstn = 1'b1;
    endtask

`ifdef FPGA_UART_TX_EN
    task automatic recv_byte(input logic [7:0] exp);
        int          lowc;
        logic [7:0]  data;
        for (int k = 0; k < 400 && uart_txd !== 1'b0; k++) tick();
        if (uart_txd !== 1'b0) begin
            check("uart_start_seen", {31'd0, uart_txd}, 32'h0);
            return;
        end
        lowc = 0;
        for (int k = 0; k < 8; k++) begin
            if (uart_txd === 1'b0) lowc++;
            tick();
        end
        check("uart_start_len", lowc, 32'd8);
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            data[i] = uart_txd;
            if (i < 7) repeat (8) tick();
        end
        check("uart_data", {24'd0, data}, {24'd0, exp});
        repeat (8) tick();
        check("uart_stop", {31'd0, uart_txd}, 32'h1);
    endtask
`endif

    initial begin
        logic [31:0] a, b;
        logic [7:0]  keys;
        int          r;

        uart_rxd = 1'b1;
        for (int i = 0; i < 8; i++) dip[i] = 8'hFF;
        sys_rstn = 1'b1;
        do_reset();

`ifdef FPGA_UART_TX_EN
        drive(32'h2, 32'h1, ~8'h04);
        recv_byte(8'h02);
        recv_byte(8'h00);
        recv_byte(8'h00);
        recv_byte(8'h00);
        check("uart_led", led_light, ~32'h2);
        do_reset();
`endif

        apply(32'h2, 32'h1, ~8'h04);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_scan();
        end
        apply(32'h12, 32'h1, ~8'h04);
        apply(32'h1, 32'h2, ~8'h01);
        apply(32'h1, 32'h2, ~8'h02);
        apply(32'h1234_5678, 32'h0, ~8'h08);
        apply(32'hDEAD_BEEF, 32'h7, 8'hFF);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 11);
            if (r == 10) b = 32'd0;
            if (r == 11) b = $urandom_range(1, 40);
            keys = 8'hFF;
            if (r < 8) keys = ~(8'h01 << r);
            else if (r == 8) keys = 8'($urandom);
            else if (r >= 10) keys = ~(8'h01 << $urandom_range(1, 7));
            apply(a, b, keys);
        end

        // Asynchronous reset between clock edges, mid-scan.
        @(posedge clk_in);
        #3;
        sys_rstn   = 1'b0;
        user_key   = 8'hFF;
        exp_result = '0;
        exp_valid  = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk_in);
        sys_rstn = 1'b1;
        apply(32'h0F0F_0F0F, 32'h4, ~8'h80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
